acc_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the accumulator datapath. Each instruction passes through fetch, decode and execute, plus a memory phase when one is needed. The block consumes the 3-bit accumulator model code produced by the accumulator decoder and issues per-cycle enables to the PC, IR, accumulator, flag, register file and data memory. It also runs the data-memory request/ready handshake with a timeout, and keeps a retired-cycle counter for benchmarking.

---
 rtl/acc_seq_ctrl_pkg.sv | 30 +++
 rtl/acc_seq_ctrl_sat.sv | 38 +++
 rtl/acc_seq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_ctrl_pkg.sv
// Shared definitions for the accumulator control sequencer.
//   state_e  : sequencer states
//   MODEL_*  : 3-bit accumulator model codes produced by the decoder
//   HALT_OP  : opcode that stops the sequencer normally
package acc_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StMem,
      StHalt
   } state_e;

   localparam logic [2:0] MODEL_INV   = 3'b000;
   localparam logic [2:0] MODEL_ALU   = 3'b001;
   localparam logic [2:0] MODEL_UNARY = 3'b010;
   localparam logic [2:0] MODEL_EQ    = 3'b011;
   localparam logic [2:0] MODEL_JMP   = 3'b100;
   localparam logic [2:0] MODEL_ST    = 3'b101;
   localparam logic [2:0] MODEL_LD    = 3'b110;
   localparam logic [2:0] MODEL_LWR   = 3'b111;

   localparam logic [5:0] HALT_OP = 6'b000111;

   // Width of the memory timeout counter; MEM_TIMEOUT is limited to 1..255.
   localparam int unsigned TMO_W = 8;

endpackage

// File: rtl/acc_seq_ctrl_sat.sv
// sat_counter: synchronous up-counter that sticks at all-ones.
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-high reset, count -> 0
//   clr_i   : synchronous clear, count -> 0 (wins over en_i)
//   en_i    : increment when not already saturated
//   count_o : current count
module sat_counter #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: multi-cycle control sequencer for the accumulator datapath.
// Walks each instruction through FETCH, DECODE, EXEC and optionally MEM, issuing
// per-cycle enables, running the data-memory request/ready handshake with a
// timeout, and counting cycles spent outside IDLE/HALT.
//   clk_i, reset_i        : clock and synchronous active-high reset
//   start_i               : leave IDLE/HALT and begin fetching
//   op_i, acc_control_i   : IR opcode and decoder model code
//   eq_flag_i             : current EQ flag (jump condition)
//   mem_ready_i           : data memory completion pulse
//   ir_load_o .. mem_we_o : datapath strobes
//   busy_o, done_o        : running / halted status
//   error_o               : sticky invalid-model or memory-timeout error
//   cycles_o              : saturating cycle count since last start
module acc_seq_ctrl
   import acc_seq_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [5:0]       op_i,
   input  logic [2:0]       acc_control_i,
   input  logic             eq_flag_i,
   input  logic             mem_ready_i,
   output logic             ir_load_o,
   output logic             pc_inc_o,
   output logic             pc_load_o,
   output logic             acc_we_o,
   output logic             flag_we_o,
   output logic             reg_we_o,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o,
   output logic [CNT_W-1:0] cycles_o
);

   // The timeout counter holds (MEM cycle index - 1), so the last allowed cycle
   // is reached when it equals MEM_TIMEOUT-1.
   localparam logic [TMO_W-1:0] TmoLast = TMO_W'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [2:0]       model_q, model_d;
   logic             error_q, error_d;
   logic [TMO_W-1:0] tmo_cnt;
   logic             in_mem;
   logic             running;
   logic             restart;

   assign in_mem  = (state_q == StMem);
   assign running = (state_q == StFetch) || (state_q == StDecode) ||
                    (state_q == StExec)  || (state_q == StMem);
   assign restart = start_i && ((state_q == StIdle) || (state_q == StHalt));

   sat_counter #(
      .Width (CNT_W)
   ) u_cycle_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (restart),
      .en_i    (running),
      .count_o (cycles_o)
   );

   // Held at zero outside MEM so every memory access gets a fresh budget.
   sat_counter #(
      .Width (TMO_W)
   ) u_tmo_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clr_i   (!in_mem),
      .en_i    (in_mem),
      .count_o (tmo_cnt)
   );

   always_comb begin
      state_d   = state_q;
      model_d   = model_q;
      error_d   = error_q;
      ir_load_o = 1'b0;
      pc_inc_o  = 1'b0;
      pc_load_o = 1'b0;
      acc_we_o  = 1'b0;
      flag_we_o = 1'b0;
      reg_we_o  = 1'b0;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      done_o    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StFetch;
               error_d = 1'b0;
            end
         end

         StFetch: begin
            ir_load_o = 1'b1;
            state_d   = StDecode;
         end

         StDecode: begin
            model_d = acc_control_i;
            if (op_i == HALT_OP) begin
               state_d = StHalt;
            end else if (acc_control_i == MODEL_INV) begin
               error_d = 1'b1;
               state_d = StHalt;
            end else begin
               state_d = StExec;
            end
         end

         StExec: begin
            unique case (model_q)
               MODEL_ALU, MODEL_UNARY: begin
                  acc_we_o = 1'b1;
                  pc_inc_o = 1'b1;
                  state_d  = StFetch;
               end
               MODEL_EQ: begin
                  flag_we_o = 1'b1;
                  pc_inc_o  = 1'b1;
                  state_d   = StFetch;
               end
               MODEL_JMP: begin
                  pc_load_o = eq_flag_i;
                  pc_inc_o  = !eq_flag_i;
                  state_d   = StFetch;
               end
               MODEL_LWR: begin
                  reg_we_o = 1'b1;
                  pc_inc_o = 1'b1;
                  state_d  = StFetch;
               end
               MODEL_ST, MODEL_LD: begin
                  state_d = StMem;
               end
               default: begin
                  // Unreachable: DECODE never lets MODEL_INV through.
                  error_d = 1'b1;
                  state_d = StHalt;
               end
            endcase
         end

         StMem: begin
            mem_req_o = 1'b1;
            mem_we_o  = (model_q == MODEL_ST);
            // Ready on the final allowed cycle still counts as success.
            if (mem_ready_i) begin
               pc_inc_o = 1'b1;
               acc_we_o = (model_q == MODEL_LD);
               state_d  = StFetch;
            end else if (tmo_cnt == TmoLast) begin
               error_d = 1'b1;
               state_d = StHalt;
            end
         end

         StHalt: begin
            done_o = 1'b1;
            if (start_i) begin
               state_d = StFetch;
               error_d = 1'b0;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         model_q <= MODEL_INV;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         model_q <= model_d;
         error_q <= error_d;
      end
   end

   assign busy_o  = running;
   assign error_o = error_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Self-checking bench for acc_seq_ctrl: table-driven EXEC decode checks, hand
// sequences for memory wait/timeout/halt/reset corners, and randomized
// instruction streams checked against an instruction-level reference model.
module tb_acc_seq_ctrl;

   localparam int         CntW       = 8;
   localparam int         MemTimeout = 15;
   localparam logic [5:0] HaltOp     = 6'b000111;

   logic            clk = 1'b0;
   logic            reset, start, eq_flag, mem_ready;
   logic [5:0]      op;
   logic [2:0]      acc_control;
   logic            ir_load, pc_inc, pc_load, acc_we, flag_we, reg_we;
   logic            mem_req, mem_we, busy, done, error;
   logic [CntW-1:0] cycles;
   logic [10:0]     got;

   always #5 clk = ~clk;

   acc_seq_ctrl #(
      .MEM_TIMEOUT (MemTimeout),
      .CNT_W       (CntW)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .op_i          (op),
      .acc_control_i (acc_control),
      .eq_flag_i     (eq_flag),
      .mem_ready_i   (mem_ready),
      .ir_load_o     (ir_load),
      .pc_inc_o      (pc_inc),
      .pc_load_o     (pc_load),
      .acc_we_o      (acc_we),
      .flag_we_o     (flag_we),
      .reg_we_o      (reg_we),
      .mem_req_o     (mem_req),
      .mem_we_o      (mem_we),
      .busy_o        (busy),
      .done_o        (done),
      .error_o       (error),
      .cycles_o      (cycles)
   );

   assign got = {ir_load, pc_inc, pc_load, acc_we, flag_we, reg_we,
                 mem_req, mem_we, busy, done, error};

   int total  = 0;
   int passed = 0;
   int ref_cnt = 0;
   bit ref_err = 1'b0;

   typedef struct {
      logic [2:0]  model;
      bit          eq;
      logic [10:0] exp;
   } vec_t;

   vec_t tbl[8];

   // Output vector order: ir, pc_inc, pc_load, acc_we, flag_we, reg_we,
   // mem_req, mem_we, busy, done, error.
   function automatic logic [10:0] ov(input bit ir, pinc, pload, acc, flag, rg,
                                      req, we, bsy, dn, err);
      return {ir, pinc, pload, acc, flag, rg, req, we, bsy, dn, err};
   endfunction

   function automatic int sat_inc(input int c);
      return (c >= (1 << CntW) - 1) ? c : c + 1;
   endfunction

   // EXEC-cycle strobes derived from the per-model rules.
   function automatic logic [10:0] exec_exp(input logic [2:0] m, input bit eq);
      case (m)
         3'd1, 3'd2: return ov(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
         3'd3:       return ov(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0);
         3'd4:       return ov(0, !eq, eq, 0, 0, 0, 0, 0, 1, 0, 0);
         3'd7:       return ov(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0);
         default:    return ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      endcase
   endfunction

   // Inputs are set just after the rising edge; outputs sampled at the falling edge.
   task automatic check(input string name, input logic [10:0] exp, input int exp_cyc);
      logic [CntW-1:0] ec;
      ec = CntW'(exp_cyc);
      @(negedge clk);
      total++;
      if (got === exp && cycles === ec) begin
         passed++;
      end else begin
         $display("FAIL %s: got out=%b cycles=%0d, expected out=%b cycles=%0d",
                  name, got, cycles, exp, ec);
      end
      @(posedge clk);
      #1;
   endtask

   // One instruction starting in FETCH. rdy = MEM cycle carrying mem_ready
   // (outside 1..MemTimeout means never). noise drives don't-care inputs randomly.
   task automatic run_instr(input logic [5:0] op_v, input logic [2:0] model, input bit eq,
                            input int rdy, input bit noise, input logic [10:0] exp_exec,
                            output bit halted);
      bit rdy_seen;
      halted   = 1'b0;
      rdy_seen = 1'b0;
      op          = noise ? 6'($urandom) : op_v;
      acc_control = 3'($urandom);
      start       = noise & 1'($urandom);
      mem_ready   = noise & 1'($urandom);
      eq_flag     = 1'($urandom);
      check("fetch", ov(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ref_cnt);
      ref_cnt = sat_inc(ref_cnt);

      op          = op_v;
      acc_control = model;
      start       = noise & 1'($urandom);
      mem_ready   = noise & 1'($urandom);
      check("decode", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ref_cnt);
      ref_cnt = sat_inc(ref_cnt);
      if (op_v == HaltOp) begin
         halted  = 1'b1;
         ref_err = 1'b0;
         return;
      end
      if (model == 3'd0) begin
         halted  = 1'b1;
         ref_err = 1'b1;
         return;
      end

      eq_flag     = eq;
      acc_control = noise ? 3'($urandom) : model;
      op          = noise ? 6'($urandom) : op_v;
      start       = noise & 1'($urandom);
      mem_ready   = noise & 1'($urandom);
      check("exec", exp_exec, ref_cnt);
      ref_cnt = sat_inc(ref_cnt);

      if (model == 3'd5 || model == 3'd6) begin
         for (int i = 1; i <= MemTimeout && !rdy_seen; i++) begin
            mem_ready = (i == rdy);
            start     = noise & 1'($urandom);
            rdy_seen  = (i == rdy);
            check("mem", ov(0, rdy_seen, 0, rdy_seen && model == 3'd6, 0, 0, 1,
                            model == 3'd5, 1, 0, 0), ref_cnt);
            ref_cnt = sat_inc(ref_cnt);
         end
         if (!rdy_seen) begin
            halted  = 1'b1;
            ref_err = 1'b1;
         end
      end
      mem_ready = 1'b0;
      start     = 1'b0;
   endtask

   task automatic halt_and_restart(input string name);
      start = 1'b0;
      check(name, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ref_err), ref_cnt);
      start = 1'b1;
      check("halt_start", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ref_err), ref_cnt);
      start   = 1'b0;
      ref_cnt = 0;
      ref_err = 1'b0;
   endtask

   initial begin
      bit          h;
      logic [5:0]  rop;
      logic [2:0]  rmodel;
      bit          req;
      int          rrdy;

      tbl[0] = '{3'b001, 1'b0, 11'b01010000100};
      tbl[1] = '{3'b010, 1'b0, 11'b01010000100};
      tbl[2] = '{3'b011, 1'b0, 11'b01001000100};
      tbl[3] = '{3'b100, 1'b0, 11'b01000000100};
      tbl[4] = '{3'b100, 1'b1, 11'b00100000100};
      tbl[5] = '{3'b111, 1'b0, 11'b01000100100};
      tbl[6] = '{3'b101, 1'b0, 11'b00000000100};
      tbl[7] = '{3'b110, 1'b1, 11'b00000000100};

      reset = 1'b1; start = 1'b0; eq_flag = 1'b0; mem_ready = 1'b0;
      op = 6'd0; acc_control = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 11'd0, 0);
      reset = 1'b0;
      check("idle", 11'd0, 0);
      mem_ready = 1'b1;
      check("idle_stray_ready", 11'd0, 0);
      mem_ready = 1'b0;
      start = 1'b1;
      check("idle_start", 11'd0, 0);
      start = 1'b0;
      ref_cnt = 0;

      // EXEC decode per model (memory ops complete on the first MEM cycle).
      foreach (tbl[i]) begin
         run_instr(6'(8'h10 + i), tbl[i].model, tbl[i].eq, 1, 1'b0, tbl[i].exp, h);
      end

      // Load with ready on the fourth MEM cycle.
      run_instr(6'h20, 3'd6, 1'b0, 4, 1'b0, exec_exp(3'd6, 1'b0), h);
      // Load with ready exactly on the timeout cycle: success.
      run_instr(6'h21, 3'd6, 1'b0, MemTimeout, 1'b0, exec_exp(3'd6, 1'b0), h);
      // Store with no ready: timeout, halt with error.
      run_instr(6'h22, 3'd5, 1'b0, 0, 1'b0, exec_exp(3'd5, 1'b0), h);
      halt_and_restart("timeout_halt");
      // HALT opcode stops after DECODE with cycles=2.
      run_instr(HaltOp, 3'd1, 1'b0, 0, 1'b0, exec_exp(3'd1, 1'b0), h);
      halt_and_restart("halt_op");
      // Invalid model code.
      run_instr(6'h23, 3'd0, 1'b0, 0, 1'b0, exec_exp(3'd0, 1'b0), h);
      halt_and_restart("invalid_model");

      // Long ALU run drives the cycle counter into saturation, then halt freezes it.
      repeat (90) run_instr(6'h01, 3'd1, 1'b0, 0, 1'b0, exec_exp(3'd1, 1'b0), h);
      run_instr(HaltOp, 3'd2, 1'b0, 0, 1'b0, exec_exp(3'd2, 1'b0), h);
      halt_and_restart("sat_halt");

      // Randomized instruction stream against the reference model.
      repeat (300) begin
         rop    = ($urandom_range(0, 39) == 0) ? HaltOp : 6'($urandom_range(8, 63));
         rmodel = ($urandom_range(0, 39) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
         req    = 1'($urandom);
         rrdy   = $urandom_range(1, MemTimeout + 1);
         run_instr(rop, rmodel, req, rrdy, 1'b1, exec_exp(rmodel, req), h);
         if (h) halt_and_restart("rand_halt");
      end

      // Reset during the second cycle of a memory wait.
      op = 6'h30; acc_control = 3'd0;
      check("rst_fetch", ov(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ref_cnt);
      ref_cnt = sat_inc(ref_cnt);
      acc_control = 3'd5;
      check("rst_decode", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ref_cnt);
      ref_cnt = sat_inc(ref_cnt);
      check("rst_exec", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ref_cnt);
      ref_cnt = sat_inc(ref_cnt);
      check("rst_mem1", ov(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), ref_cnt);
      ref_cnt = sat_inc(ref_cnt);
      reset = 1'b1;
      check("rst_mem2", ov(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0), ref_cnt);
      reset = 1'b0;
      ref_cnt = 0;
      check("after_reset", 11'd0, 0);
      mem_ready = 1'b1;
      check("stray_ready", 11'd0, 0);
      mem_ready = 1'b0;
      check("idle_settled", 11'd0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
